mcs4_mem_arbiter: RTL and testbench

Shares the single-port program/data memory of the MCS-4 IP between two requesters: the AXI4 slave front-end (host bursts of up to 8 beats, as used for loading and reading back memory from the PS) and the emulated 4004 core's fetch/data port (single-word accesses). A host burst holds the memory for its full length. Between transactions, grants alternate round-robin. The block sits between the AXI slave logic and the memory instance, and drives the memory port directly.

---
 rtl/mcs4_mem_arbiter_if.sv | 52 +++++
 rtl/mcs4_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mcs4_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_mem_arbiter_if.sv
// Bus bundle between the AXI host front-end, the 4004 core port and the shared memory.
// The arbiter uses the slave modport; the surrounding logic uses the master modport.
interface mcs4_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_write;
    logic [ADDR_W-1:0] host_req_addr;
    logic [2:0]        host_req_len;
    logic [DATA_W-1:0] host_wdata;
    logic              host_wvalid;
    logic              host_wready;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              host_rlast;
    logic              host_rready;
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_write;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  host_req_valid, host_req_write, host_req_addr, host_req_len,
        input  host_wdata, host_wvalid, host_rready,
        input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_wdata,
        input  mem_rdata,
        output host_req_ready, host_wready, host_rdata, host_rvalid, host_rlast,
        output cpu_req_ready, cpu_rdata, cpu_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output host_req_valid, host_req_write, host_req_addr, host_req_len,
        output host_wdata, host_wvalid, host_rready,
        output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_wdata,
        output mem_rdata,
        input  host_req_ready, host_wready, host_rdata, host_rvalid, host_rlast,
        input  cpu_req_ready, cpu_rdata, cpu_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mcs4_mem_arbiter.sv
// Arbitrates the single-port MCS-4 memory between host bursts (up to 8 beats) and single-word core accesses.
// Define MCS4_ARB_CPU_PRIO_EN to make the core win every simultaneous request; otherwise grants alternate round-robin.
module mcs4_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    mcs4_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        H_WR      = 3'd1,
        H_RD_ISS  = 3'd2,
        H_RD_WAIT = 3'd3,
        C_RD_WAIT = 3'd4
    } state_t;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              first_q, first_d;

    logic              idle_s;
    logic              grant_host_s;
    logic              grant_cpu_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              host_rvalid_s;
    logic              cpu_rvalid_s;

    // Grants are suppressed while reset is asserted so no memory access leaks out of reset.
    assign idle_s = (state_q == IDLE) && !ARESET;
`ifdef MCS4_ARB_CPU_PRIO_EN
    assign grant_host_s = idle_s && bus.host_req_valid && !bus.cpu_req_valid;
`else
    assign grant_host_s = idle_s && bus.host_req_valid &&
                          (!bus.cpu_req_valid || (last_grant_q == GRANT_CPU));
`endif
    assign grant_cpu_s  = idle_s && bus.cpu_req_valid && !grant_host_s;

    // Next-state, burst bookkeeping and memory-port drive.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        first_d      = 1'b0;
        mem_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = {ADDR_W{1'b0}};
        mem_wdata_s  = {DATA_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (grant_host_s) begin
                    addr_d       = bus.host_req_addr;
                    cnt_d        = bus.host_req_len;
                    last_grant_d = GRANT_HOST;
                    if (bus.host_req_write) begin
                        state_d = H_WR;
                    end else begin
                        state_d = H_RD_ISS;
                    end
                end else if (grant_cpu_s) begin
                    last_grant_d = GRANT_CPU;
                    mem_en_s     = 1'b1;
                    mem_we_s     = bus.cpu_req_write;
                    mem_addr_s   = bus.cpu_req_addr;
                    if (bus.cpu_req_write) begin
                        mem_wdata_s = bus.cpu_wdata;
                        state_d     = IDLE;
                    end else begin
                        mem_wdata_s = {DATA_W{1'b0}};
                        state_d     = C_RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            H_WR: begin
                if (bus.host_wvalid) begin
                    mem_en_s    = 1'b1;
                    mem_we_s    = 1'b1;
                    mem_addr_s  = addr_q;
                    mem_wdata_s = bus.host_wdata;
                    addr_d      = addr_q + ADDR_W'(1);
                    if (cnt_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else begin
                    state_d = H_WR;
                end
            end
            H_RD_ISS: begin
                mem_en_s   = 1'b1;
                mem_addr_s = addr_q;
                first_d    = 1'b1;
                state_d    = H_RD_WAIT;
            end
            H_RD_WAIT: begin
                // Memory data is only valid on the first wait cycle; the hold register covers rready stalls.
                if (first_q) begin
                    hold_d = bus.mem_rdata;
                end else begin
                    hold_d = hold_q;
                end
                if (bus.host_rready) begin
                    if (cnt_q == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_q - 3'd1;
                        state_d = H_RD_ISS;
                    end
                end else begin
                    state_d = H_RD_WAIT;
                end
            end
            C_RD_WAIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            cnt_q        <= 3'd0;
            last_grant_q <= GRANT_CPU;
            hold_q       <= {DATA_W{1'b0}};
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            first_q      <= first_d;
        end
    end

    assign host_rvalid_s      = (state_q == H_RD_WAIT);
    assign cpu_rvalid_s       = (state_q == C_RD_WAIT);

    assign bus.host_req_ready = grant_host_s;
    assign bus.cpu_req_ready  = grant_cpu_s;
    assign bus.host_wready    = (state_q == H_WR);
    assign bus.host_rvalid    = host_rvalid_s;
    assign bus.host_rlast     = host_rvalid_s && (cnt_q == 3'd0);
    assign bus.host_rdata     = !host_rvalid_s ? {DATA_W{1'b0}} :
                                (first_q ? bus.mem_rdata : hold_q);
    assign bus.cpu_rvalid     = cpu_rvalid_s;
    assign bus.cpu_rdata      = cpu_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.mem_en         = mem_en_s;
    assign bus.mem_we         = mem_we_s;
    assign bus.mem_addr       = mem_addr_s;
    assign bus.mem_wdata      = mem_wdata_s;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_mcs4_mem_arbiter.sv
// Bench for mcs4_mem_arbiter: arbitration vector table, directed burst/reset sequences and
// randomized traffic checked against a word-array memory reference and a last-winner model.
module tb_mcs4_mem_arbiter;
`ifdef MCS4_ARB_CPU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic ACLK;
    logic ARESET;
    mcs4_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();
    mcs4_mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_count = 0;
    bit          model_last_host;
    logic [31:0] mem_arr [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] mem_rdata_r = 32'd0;
    logic [116:0] outs_s;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural single-port memory: 1-cycle read latency.
    always @(posedge ACLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_arr[bus.mem_addr] <= bus.mem_wdata;
                wr_count <= wr_count + 1;
            end else begin
                mem_rdata_r <= mem_arr[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_r;

    assign outs_s = {bus.host_req_ready, bus.host_wready, bus.host_rvalid, bus.host_rlast,
                     bus.host_rdata, bus.cpu_req_ready, bus.cpu_rvalid, bus.cpu_rdata,
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.host_req_valid = 1'b0; bus.host_req_write = 1'b0; bus.host_req_addr = 12'h000;
        bus.host_req_len = 3'd0; bus.host_wdata = 32'd0; bus.host_wvalid = 1'b0;
        bus.host_rready = 1'b0; bus.cpu_req_valid = 1'b0; bus.cpu_req_write = 1'b0;
        bus.cpu_req_addr = 12'h000; bus.cpu_wdata = 32'd0;
    endtask

    // Runs the write beats of an accepted host burst with optional random wvalid gaps.
    task automatic host_write_beats(input string nm, input logic [11:0] a, input int len,
                                    input bit rnd, input logic [31:0] base);
        int beat = 0;
        int cyc = 0;
        logic [11:0] ea;
        logic [31:0] wd;
        while (beat <= len && cyc < 200) begin
            bus.host_wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wd = rnd ? $urandom : base + 32'(beat);
            bus.host_wdata = wd;
            ea = a + 12'(beat);
            @(negedge ACLK);
            if (bus.host_wvalid) begin
                chk(nm, {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.cpu_req_ready},
                        {1'b1, 1'b1, ea, wd, 1'b1, 1'b0});
                ref_mem[ea] = wd;
                beat++;
            end else begin
                chk({nm, "_stall"}, {bus.mem_en, bus.host_wready}, {1'b0, 1'b1});
            end
            next_cycle();
            cyc++;
        end
        bus.host_wvalid = 1'b0;
        if (beat <= len) chk({nm, "_timeout"}, 32'(beat), 32'(len + 1));
    endtask

    // Collects the read beats of an accepted host burst under an rready pattern.
    task automatic host_read_beats(input string nm, input logic [11:0] a, input int len, input bit rnd);
        int beat = 0;
        int cyc = 0;
        bit prev_valid = 1'b0;
        bit prev_hs = 1'b0;
        logic [31:0] prev_data = 32'd0;
        logic [11:0] ea;
        while (beat <= len && cyc < 300) begin
            bus.host_rready = rnd ? ($urandom_range(0, 1) != 0) : (cyc % 2 == 1);
            ea = a + 12'(beat);
            @(negedge ACLK);
            if (cyc == 0) chk({nm, "_first_iss"}, {bus.host_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr},
                                                  {1'b0, 1'b1, 1'b0, a});
            if (cyc == 1) chk({nm, "_first_rvalid"}, bus.host_rvalid, 1'b1);
            if (bus.host_rvalid) begin
                if (prev_valid && !prev_hs) chk({nm, "_stable"}, bus.host_rdata, prev_data);
                chk({nm, "_beat"}, {bus.host_rdata, bus.host_rlast}, {ref_mem[ea], (beat == len)});
                if (bus.host_rready) beat++;
            end
            prev_valid = bus.host_rvalid;
            prev_hs = bus.host_rvalid && bus.host_rready;
            prev_data = bus.host_rdata;
            next_cycle();
            cyc++;
        end
        bus.host_rready = 1'b0;
        if (beat <= len) chk({nm, "_timeout"}, 32'(beat), 32'(len + 1));
    endtask

    typedef struct packed {
        logic       hv;
        logic       cv;
        logic [1:0] exp_rr;  // {host_req_ready, cpu_req_ready}
        logic [1:0] exp_pr;
    } arb_vec_t;

    arb_vec_t vecs [10];

    initial begin : main
        logic [1:0]  exp;
        logic [11:0] h_addr, c_addr;
        logic [31:0] c_wdata;
        int          h_len, wr_base, bad;
        bit          hv, cv, h_wr, c_wr, exp_host, exp_cpu;

        vecs[0] = '{1'b1, 1'b0, 2'b10, 2'b10};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 2'b01};
        vecs[2] = '{1'b1, 1'b1, 2'b10, 2'b01};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 2'b10, 2'b01};
        vecs[5] = '{1'b1, 1'b1, 2'b01, 2'b01};
        vecs[6] = '{1'b1, 1'b0, 2'b10, 2'b10};
        vecs[7] = '{1'b1, 1'b1, 2'b01, 2'b01};
        vecs[8] = '{1'b0, 1'b0, 2'b00, 2'b00};
        vecs[9] = '{1'b1, 1'b1, 2'b10, 2'b01};

        for (int i = 0; i < 4096; i++) begin
            mem_arr[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        clear_inputs();

        // Reset with every request asserted: all outputs must read zero.
        ARESET = 1'b0;
        #1 ARESET = 1'b1;
        bus.host_req_valid = 1'b1; bus.cpu_req_valid = 1'b1; bus.cpu_req_write = 1'b1;
        bus.host_wvalid = 1'b1; bus.host_rready = 1'b1;
        @(negedge ACLK);
        chk("reset_outputs", 128'(outs_s), 128'd0);
        next_cycle();
        clear_inputs();
        ARESET = 1'b0;
        model_last_host = 1'b0;
        next_cycle();

        // Arbitration table: host commands are single-beat writes, core commands are writes.
        for (int i = 0; i < 10; i++) begin
            bus.host_req_valid = vecs[i].hv; bus.host_req_write = 1'b1;
            bus.host_req_addr = 12'h200 + 12'(i); bus.host_req_len = 3'd0;
            bus.cpu_req_valid = vecs[i].cv; bus.cpu_req_write = 1'b1;
            bus.cpu_req_addr = 12'h300 + 12'(i); bus.cpu_wdata = 32'hC000_0000 + 32'(i);
            exp = PRIO ? vecs[i].exp_pr : vecs[i].exp_rr;
            @(negedge ACLK);
            chk("arb_ready", {bus.host_req_ready, bus.cpu_req_ready}, exp);
            if (exp == 2'b01)
                chk("arb_cpu_write", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                                     {1'b1, 1'b1, 12'h300 + 12'(i), 32'hC000_0000 + 32'(i)});
            else
                chk("arb_no_mem", bus.mem_en, 1'b0);
            next_cycle();
            bus.host_req_valid = 1'b0; bus.cpu_req_valid = 1'b0;
            if (exp == 2'b10) begin
                model_last_host = 1'b1;
                host_write_beats("arb_host_beat", 12'h200 + 12'(i), 0, 1'b0, 32'hA000_0000 + 32'(i));
            end else if (exp == 2'b01) begin
                model_last_host = 1'b0;
                ref_mem[12'h300 + 12'(i)] = 32'hC000_0000 + 32'(i);
            end
        end

        // 8-beat host write at 0x010 while the core waits to read 0x017.
        bus.host_req_valid = 1'b1; bus.host_req_write = 1'b1;
        bus.host_req_addr = 12'h010; bus.host_req_len = 3'd7;
        @(negedge ACLK);
        chk("wr8_accept", {bus.host_req_ready, bus.busy}, {1'b1, 1'b0});
        next_cycle();
        bus.host_req_valid = 1'b0;
        model_last_host = 1'b1;
        bus.cpu_req_valid = 1'b1; bus.cpu_req_write = 1'b0; bus.cpu_req_addr = 12'h017;
        host_write_beats("wr8_beat", 12'h010, 7, 1'b0, 32'd1);
        @(negedge ACLK);
        chk("cpu_rd_accept", {bus.busy, bus.cpu_req_ready, bus.mem_en, bus.mem_we, bus.mem_addr},
                             {1'b0, 1'b1, 1'b1, 1'b0, 12'h017});
        next_cycle();
        bus.cpu_req_valid = 1'b0;
        model_last_host = 1'b0;
        @(negedge ACLK);
        chk("cpu_rd_data", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b1, 32'h0000_0008});
        next_cycle();
        @(negedge ACLK);
        chk("cpu_rvalid_pulse", bus.cpu_rvalid, 1'b0);
        next_cycle();

        // 8-beat host read of 0x010 with rready toggling every other cycle.
        bus.host_req_valid = 1'b1; bus.host_req_write = 1'b0;
        bus.host_req_addr = 12'h010; bus.host_req_len = 3'd7;
        @(negedge ACLK);
        chk("rd8_accept", bus.host_req_ready, 1'b1);
        next_cycle();
        bus.host_req_valid = 1'b0;
        model_last_host = 1'b1;
        host_read_beats("rd8", 12'h010, 7, 1'b0);

        // Address wrap within a burst.
        bus.host_req_valid = 1'b1; bus.host_req_write = 1'b1;
        bus.host_req_addr = 12'hFFE; bus.host_req_len = 3'd3;
        @(negedge ACLK);
        chk("wrap_accept", bus.host_req_ready, 1'b1);
        next_cycle();
        bus.host_req_valid = 1'b0;
        host_write_beats("wrap_beat", 12'hFFE, 3, 1'b0, 32'hD0);

        // Reset after the third beat of an 8-beat write.
        wr_base = wr_count;
        bus.host_req_valid = 1'b1; bus.host_req_write = 1'b1;
        bus.host_req_addr = 12'h100; bus.host_req_len = 3'd7;
        @(negedge ACLK);
        chk("rst_burst_accept", bus.host_req_ready, 1'b1);
        next_cycle();
        bus.host_req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.host_wvalid = 1'b1;
            bus.host_wdata = 32'hE0 + 32'(b);
            ref_mem[12'h100 + 12'(b)] = 32'hE0 + 32'(b);
            next_cycle();
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("rst_mid_outputs", 128'(outs_s), 128'd0);
        next_cycle();
        ARESET = 1'b0;
        model_last_host = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge ACLK);
            chk("rst_no_mem_en", {bus.mem_en, bus.busy, bus.host_wready}, 3'b000);
            next_cycle();
        end
        bus.host_wvalid = 1'b0;
        chk("rst_write_count", 32'(wr_count - wr_base), 32'd3);
        bus.host_req_valid = 1'b1; bus.host_req_write = 1'b1;
        bus.host_req_addr = 12'h120; bus.host_req_len = 3'd0;
        @(negedge ACLK);
        chk("rst_next_accept", bus.host_req_ready, 1'b1);
        next_cycle();
        bus.host_req_valid = 1'b0;
        model_last_host = 1'b1;
        host_write_beats("rst_next_beat", 12'h120, 0, 1'b0, 32'hF0);

        // Randomized mixed traffic against the memory reference and last-winner model.
        for (int it = 0; it < 300; it++) begin
            hv = ($urandom_range(0, 1) != 0);
            cv = ($urandom_range(0, 1) != 0);
            if (!hv && !cv) hv = 1'b1;
            h_wr = ($urandom_range(0, 1) != 0);
            h_addr = ($urandom_range(0, 3) == 0) ? (12'hFF8 + 12'($urandom_range(0, 7)))
                                                  : 12'($urandom_range(0, 63));
            h_len = $urandom_range(0, 7);
            c_wr = ($urandom_range(0, 1) != 0);
            c_addr = 12'($urandom_range(0, 63));
            c_wdata = $urandom;
            exp_host = hv && (!cv || (!PRIO && !model_last_host));
            exp_cpu = cv && !exp_host;
            bus.host_req_valid = hv; bus.host_req_write = h_wr;
            bus.host_req_addr = h_addr; bus.host_req_len = 3'(h_len);
            bus.cpu_req_valid = cv; bus.cpu_req_write = c_wr;
            bus.cpu_req_addr = c_addr; bus.cpu_wdata = c_wdata;
            @(negedge ACLK);
            chk("rnd_grant", {bus.host_req_ready, bus.cpu_req_ready}, {exp_host, exp_cpu});
            if (exp_cpu) begin
                chk("rnd_cpu_mem", {bus.mem_en, bus.mem_we, bus.mem_addr}, {1'b1, c_wr, c_addr});
                if (c_wr) chk("rnd_cpu_wdata", bus.mem_wdata, c_wdata);
            end
            next_cycle();
            bus.host_req_valid = 1'b0; bus.cpu_req_valid = 1'b0;
            if (exp_host) begin
                model_last_host = 1'b1;
                if (h_wr) host_write_beats("rnd_wbeat", h_addr, h_len, 1'b1, 32'd0);
                else host_read_beats("rnd_rd", h_addr, h_len, 1'b1);
            end else begin
                model_last_host = 1'b0;
                if (c_wr) begin
                    ref_mem[c_addr] = c_wdata;
                end else begin
                    @(negedge ACLK);
                    chk("rnd_cpu_rdata", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b1, ref_mem[c_addr]});
                    next_cycle();
                end
            end
        end

        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem_arr[i] !== ref_mem[i]) bad++;
        end
        chk("final_mem_words_differing", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
